// File: rtl/sm_level_driver_if.sv
// Bundle carrying the request handshake, level feedback and the d/r step-pulse
// lines between the level driver (master) and its environment (slave).
interface sm_level_driver_if;
    logic       start;
    logic [1:0] target;
    logic       q1;
    logic       q0;
    logic       d;
    logic       r;
    logic       busy;
    logic       done;
    logic       err;

    // start is a one-cycle request, honoured only while the driver is idle;
    // done (with err on timeout) is a one-cycle strobe, with no back-pressure.
    modport master (
        input  start, target, q1, q0,
        output d, r, busy, done, err
    );

    modport slave (
        output start, target, q1, q0,
        input  d, r, busy, done, err
    );
endinterface

// File: rtl/sm_level_driver.sv
// Steps a four-level up/down state machine to a requested level with spaced
// d/r pulses, verifying {q1,q0} after every step and flagging a timeout.
module sm_level_driver #(
    parameter int PULSE_HIGH = 1,
    parameter int PULSE_GAP  = 1,
    parameter int TIMEOUT    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    sm_level_driver_if.master   bus,
    output logic [2:0]          dbg_state_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PULSE = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam int CW = 16;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    tgt_q, tgt_d;
    logic [1:0]    exp_q, exp_d;
    logic          up_q, up_d;
    logic          err_flag_q, err_flag_d;
    logic          acc_q, acc_d;
    logic          d_q, r_q, busy_q, done_q, err_q;
    logic [1:0]    fb;

    assign fb = {bus.q1, bus.q0};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        exp_d      = exp_q;
        up_d       = up_q;
        err_flag_d = err_flag_q;
        acc_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Accepted start is held for one cycle so pulses begin in cycle 1.
                if (acc_q) begin
                    err_flag_d = 1'b0;
                    cnt_d      = '0;
                    if (tgt_q == fb) begin
                        state_d = S_FIN;
                    end else begin
                        up_d    = (tgt_q > fb);
                        exp_d   = (tgt_q > fb) ? fb + 2'd1 : fb - 2'd1;
                        state_d = S_PULSE;
                    end
                end else if (bus.start) begin
                    acc_d = 1'b1;
                    tgt_d = bus.target;
                end
            end
            S_PULSE: begin
                if (cnt_q == CW'(PULSE_HIGH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(PULSE_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (fb == exp_q) begin
                    if (exp_q == tgt_q) begin
                        state_d = S_FIN;
                    end else begin
                        exp_d   = up_q ? exp_q + 2'd1 : exp_q - 2'd1;
                        cnt_d   = '0;
                        state_d = S_PULSE;
                    end
                end else if (cnt_q + 1'b1 == CW'(TIMEOUT)) begin
                    err_flag_d = 1'b1;
                    state_d    = S_FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tgt_q      <= 2'd0;
            exp_q      <= 2'd0;
            up_q       <= 1'b0;
            err_flag_q <= 1'b0;
            acc_q      <= 1'b0;
            d_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            exp_q      <= exp_d;
            up_q       <= up_d;
            err_flag_q <= err_flag_d;
            acc_q      <= acc_d;
            d_q        <= (state_d == S_PULSE) &&  up_d;
            r_q        <= (state_d == S_PULSE) && !up_d;
            busy_q     <= (state_d == S_PULSE) || (state_d == S_GAP) || (state_d == S_WAIT);
            done_q     <= (state_d == S_FIN);
            err_q      <= (state_d == S_FIN) && err_flag_d;
        end
    end

    assign bus.d       = d_q;
    assign bus.r       = r_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sm_level_driver.sv
// Bench for sm_level_driver: a behavioural level machine answers the pulses and
// a trace model predicts {d,r,busy,done,err} for every cycle of each request.
module tb_sm_level_driver;

  localparam int PH = 1;
  localparam int PG = 1;
  localparam int TO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_level_driver_if bus();
  logic [2:0] dbg_state;

  sm_level_driver #(.PULSE_HIGH(PH), .PULSE_GAP(PG), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  // level state machine model: steps on each cycle it samples d or r high
  logic [1:0] lvl = 2'd0;
  logic       lvl_ld = 1'b0;
  logic [1:0] lvl_ld_v = 2'd0;
  logic       stuck_en = 1'b0;
  logic [1:0] stuck_v = 2'd0;

  always @(posedge clk) begin
    if (lvl_ld) lvl <= lvl_ld_v;
    else if (bus.d && lvl != 2'd3) lvl <= lvl + 2'd1;
    else if (bus.r && lvl != 2'd0) lvl <= lvl - 2'd1;
  end

  assign {bus.q1, bus.q0} = stuck_en ? stuck_v : lvl;

  // scoreboard
  logic [4:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [4:0] outs();
    return {bus.d, bus.r, bus.busy, bus.done, bus.err};
  endfunction

  // Expected trace from cycle 0 onward: every step is PH pulse cycles, PG gap
  // cycles and one feedback cycle; stuck feedback means one pulse then TO waits.
  function automatic void build_trace(input int from, input int to, input bit stuck);
    int  n;
    bit  up;
    exp_q.delete();
    exp_q.push_back(5'b00000);
    if (from == to) begin
      exp_q.push_back(5'b00010);
      return;
    end
    up = (to > from);
    n  = up ? to - from : from - to;
    if (stuck) n = 1;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < PH; i++) exp_q.push_back({up, !up, 3'b100});
      for (int i = 0; i < PG; i++) exp_q.push_back(5'b00100);
      if (stuck) begin
        for (int i = 0; i < TO; i++) exp_q.push_back(5'b00100);
        exp_q.push_back(5'b00011);
        return;
      end
      exp_q.push_back(5'b00100);
    end
    exp_q.push_back(5'b00010);
  endfunction

  // driver tasks
  task automatic set_level(input logic [1:0] v);
    @(negedge clk);
    lvl_ld   = 1'b1;
    lvl_ld_v = v;
    @(negedge clk);
    lvl_ld   = 1'b0;
  endtask

  task automatic do_req(input int from, input int to, input bit stuck, input bit chaos);
    int c;
    set_level(2'(from));
    stuck_en = stuck;
    stuck_v  = 2'(from);
    build_trace(from, to, stuck);
    chaos = chaos && (exp_q.size() > 4);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.target = 2'(to);
    @(posedge clk);
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (chaos && c == 2) begin
        bus.start  = 1'b1;
        bus.target = 2'($urandom_range(0, 3));
      end
      check($sformatf("trace %0d->%0d c%0d", from, to, c), 32'(outs()), 32'(exp_q.pop_front()));
      check($sformatf("d_r_excl c%0d", c), 32'(bus.d & bus.r), 32'd0);
      c++;
    end
    bus.start = 1'b0;
    if (!stuck) check($sformatf("final_lvl %0d->%0d", from, to), 32'(lvl), 32'(to));
    stuck_en = 1'b0;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.target = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", 32'(outs()), 32'd0);

    // directed cases from the test plan
    do_req(0, 3, 1'b0, 1'b0);
    do_req(3, 1, 1'b0, 1'b0);
    do_req(2, 2, 1'b0, 1'b0);
    do_req(0, 2, 1'b1, 1'b0);
    do_req(1, 3, 1'b0, 1'b1);
    do_req(3, 0, 1'b0, 1'b1);

    // asynchronous reset while d is high
    set_level(2'd0);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.target = 2'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("pre_reset_d", 32'(bus.d), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_d", 32'(bus.d), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_lvl_kept", 32'(lvl), 32'd0);
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'(outs()), 32'd0);
    do_req(0, 2, 1'b0, 1'b0);

    // randomized requests
    for (int i = 0; i < 30; i++) begin
      do_req($urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sm_level_driver.md
# sm_level_driver

Command-side driver for the four-level up/down state machine (levels 0–3, stepped by rising edges on its `d`/`r` inputs and reported on `Q1`/`Q0`). It accepts a requested 2-bit target level and emits correctly spaced single-step pulses on `d` (up) or `r` (down). It checks the machine's `{Q1,Q0}` feedback after every step until the target is reached, then reports completion or a timeout error. It sits between control logic or a test sequencer and the level state machine, and is the transmitting end of the `d`/`r` pulse interface.

## Interface
- `PULSE_HIGH`, default 1: cycles `d`/`r` is held high per step; legal range ≥1.
- `PULSE_GAP`, default 1: cycles `d`/`r` is held low after each pulse, before feedback is checked; legal range ≥1. Guarantees the receiver sees a fresh rising edge.
- `TIMEOUT`, default 4: maximum WAIT cycles allowed for feedback to reach the expected level; legal range ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only while idle.
- `target`  in  2  requested level; captured on the accepted `start`.
- `q1`, `q0`  in  1 each  level feedback from the state machine.
- `d`  out  1  step-up pulse, registered.
- `r`  out  1  step-down pulse, registered.
- `busy`  out  1  high while a request is in progress.
- `done`  out  1  one-cycle completion strobe.
- `err`  out  1  one-cycle strobe, coincident with `done`, marking a timeout failure.

## Operation
- States: IDLE, PULSE, GAP, WAIT, FIN.
- Reset (asynchronous, any state): IDLE; `d`=`r`=`busy`=`done`=`err`=0; all counters cleared. A pulse in flight is truncated immediately.
- IDLE: when `start`=1, capture `target` into `tgt` and compare it with `fb={q1,q0}`.
  - `tgt==fb`: go to FIN with no pulses.
  - Otherwise: `dir`=up if `tgt>fb`, else down; `exp` = `fb±1`; go to PULSE.
- PULSE: drive `d` (up) or `r` (down) high for `PULSE_HIGH` cycles, then go to GAP.
- GAP: both outputs low for `PULSE_GAP` cycles, then go to WAIT with the timeout counter cleared.
- WAIT: both outputs low.
  - `fb==exp` and `exp==tgt`: go to FIN.
  - `fb==exp` and `exp!=tgt`: set `exp` to `exp±1` (same `dir`) and go to PULSE.
  - Otherwise: increment the counter. If it reaches `TIMEOUT`, set the error flag and go to FIN.
- FIN: `done`=1 for exactly one cycle; `err`=1 in that cycle if the error flag is set; `busy`=0; return to IDLE.
- `busy` is 1 in PULSE, GAP and WAIT, and 0 in IDLE and FIN.
- `d` and `r` are never high in the same cycle.
- `start` is ignored in every state except IDLE. `target` changes after capture have no effect.
- Arithmetic on `exp` is 2-bit. Wrap-around cannot occur, because stepping stops at `tgt`, which lies in 0–3.
- Feedback moving the wrong way, or changing spontaneously, is treated as a mismatch and ends in timeout.

## Timing
- "Cycle n" means the clock period after the n-th rising edge following the edge that sampled `start`; cycle 1 is the first.
- Receiver assumption: it updates its level on the edge that samples `d`/`r` high, so `fb` changes one cycle after the pulse begins.
- Each step takes `PULSE_HIGH + PULSE_GAP + 1` cycles when feedback arrives promptly (3 with defaults).
- N-step request, defaults: pulses high in cycles 1, 4, …, 3N−2; `busy` high in cycles 1..3N; `done` in cycle 3N+1.
- Zero-step request: `done` in cycle 1, `busy` never asserted.
- Timeout: `done`=`err`=1 in the cycle after the `TIMEOUT`-th mismatching WAIT cycle.
- A new `start` is accepted in the cycle after `done`, at the earliest.

## Test plan
- Driver connected to the level state machine at level 0, `start` with `target`=3, defaults → `d` high in cycles 1, 4, 7; `r` never high; `done` in cycle 10 with `err`=0; final `{Q1,Q0}`=11.
- From level 3, `target`=1 → `r` high in cycles 1 and 4; `done` in cycle 7; `{Q1,Q0}`=01.
- `target` equal to the current level → no pulses; `busy`=0 throughout; `done` in cycle 1.
- Feedback tied to 00, `target`=2 → one `d` pulse in cycle 1, then `done`=`err`=1 in cycle 7 (WAIT cycles 3–6 mismatch; `TIMEOUT`=4).
- `start` pulsed and `target` changed while `busy` → both ignored; the original request completes unchanged.
- `rst_n` asserted while `d`=1 mid-request → `d`=0 and `busy`=0 asynchronously; after release, the block is idle and the next `start` executes normally.
